// File: rtl/pic_sync_core.sv
// Programmable interrupt controller core: edge/level requests, mask, IRR/ISR tracking,
// fixed or rotating priority, and a valid/ready vector handshake toward the CPU.
module pic_sync_core #(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = 8,
    parameter int DATA_W  = 16,
    parameter int IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic                wr_en,
    input  logic [1:0]          addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W-1:0]   rd_data,
    output logic                int_out,
    input  logic                inta,
    output logic                vec_valid,
    input  logic                vec_ready,
    output logic [VEC_W-1:0]    vec_data
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_IRQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_VEC} state_t;

    state_t               state, state_nxt;
    logic [NUM_IRQ-1:0]   irq_q, irr_edge, irr_edge_nxt, irr;
    logic [NUM_IRQ-1:0]   isr, isr_nxt, mask;
    logic [2:0]           cfg;
    logic [VEC_W-1:0]     base, vec_reg;
    logic [IDX_W-1:0]     low, low_nxt, win_idx;
    logic                 spur;
    logic [DATA_W-1:0]    rd_nxt;

    logic                 cand_found, isr_found, cand_ok;
    logic [IDX_W-1:0]     cand_idx, isr_top;
    logic                 cfg_wr, mask_wr, base_wr, eoi_wr, grant, accept;
    logic                 eoi_hit;
    logic [IDX_W-1:0]     eoi_idx, eoi_spec;
    logic                 unused_wr;

    // Highest-priority set bit of v: scan from low+1 upward with wrap.
    function automatic logic [IDX_W:0] pick(input logic [NUM_IRQ-1:0] v,
                                            input logic [IDX_W-1:0] lo);
        logic             found;
        logic [IDX_W-1:0] idx, id;
        logic [IDX_W:0]   sum;
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_IRQ; k >= 1; k--) begin
            sum = {1'b0, lo} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_IRQ)) sum = sum - (IDX_W+1)'(NUM_IRQ);
            id = sum[IDX_W-1:0];
            if (v[id]) begin
                found = 1'b1;
                idx   = id;
            end
        end
        return {found, idx};
    endfunction

    // Priority rank of index i: 0 is highest, NUM_IRQ-1 is the pointer itself.
    function automatic logic [IDX_W:0] rank(input logic [IDX_W-1:0] i,
                                            input logic [IDX_W-1:0] lo);
        logic [IDX_W:0] r;
        r = {1'b0, i} + (IDX_W+1)'(NUM_IRQ - 1) - {1'b0, lo};
        if (r >= (IDX_W+1)'(NUM_IRQ)) r = r - (IDX_W+1)'(NUM_IRQ);
        return r;
    endfunction

    assign irr = cfg[0] ? irq_q : irr_edge;
    assign {cand_found, cand_idx} = pick(irr & ~mask, low);
    assign {isr_found, isr_top}   = pick(isr, low);
    assign cand_ok = cand_found && (!isr_found || (rank(cand_idx, low) < rank(isr_top, low)));

    assign cfg_wr  = wr_en && (addr == 2'd0);
    assign mask_wr = wr_en && (addr == 2'd1);
    assign base_wr = wr_en && (addr == 2'd2);
    assign eoi_wr  = wr_en && (addr == 2'd3);
    assign grant   = (state == S_IDLE) && inta && !cfg_wr;
    assign accept  = (state == S_VEC) && vec_ready;

    assign eoi_spec = wr_data[IDX_W-1:0];
    assign eoi_idx  = wr_data[DATA_W-1] ? isr_top : eoi_spec;
    assign eoi_hit  = wr_data[DATA_W-1] ? isr_found
                    : (({1'b0, eoi_spec} < (IDX_W+1)'(NUM_IRQ)) && isr[eoi_spec]);
    assign unused_wr = ^wr_data;

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (inta) state_nxt = S_GRANT;
            S_GRANT: state_nxt = S_VEC;
            S_VEC:   if (vec_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (cfg_wr) state_nxt = S_IDLE;
    end

    // FSM: outputs
    always_comb begin
        vec_valid = (state == S_VEC);
        vec_data  = vec_reg;
    end

    // Request/in-service bookkeeping; the grant set is applied last so it wins over EOI.
    always_comb begin
        irr_edge_nxt = cfg[0] ? '0 : irr_edge;
        if (grant && cand_found && !cfg[0]) irr_edge_nxt[cand_idx] = 1'b0;
        if (!cfg[0]) irr_edge_nxt = irr_edge_nxt | (irq_in & ~irq_q);

        isr_nxt = isr;
        low_nxt = low;
        if (accept && cfg[1] && !spur) begin
            isr_nxt[win_idx] = 1'b0;
            if (cfg[2]) low_nxt = win_idx;
        end
        if (eoi_wr && eoi_hit) begin
            isr_nxt[eoi_idx] = 1'b0;
            if (cfg[2]) low_nxt = eoi_idx;
        end
        if (grant && cand_found) isr_nxt[cand_idx] = 1'b1;
    end

    always_comb begin
        rd_nxt = '0;
        case (addr)
            2'd0: rd_nxt = DATA_W'(cfg);
            2'd1: rd_nxt = DATA_W'(mask);
            2'd2: rd_nxt = DATA_W'(irr);
            2'd3: rd_nxt = DATA_W'(isr);
            default: rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q    <= '0;
            irr_edge <= '0;
            isr      <= '0;
            mask     <= '0;
            cfg      <= '0;
            base     <= '0;
            low      <= LAST;
            win_idx  <= '0;
            spur     <= 1'b0;
            vec_reg  <= '0;
            int_out  <= 1'b0;
            rd_data  <= '0;
        end else begin
            irq_q   <= irq_in;
            rd_data <= rd_nxt;
            int_out <= cand_ok && (state == S_IDLE) && (state_nxt == S_IDLE) && !cfg_wr;
            if (cfg_wr) begin
                cfg      <= wr_data[2:0];
                irr_edge <= '0;
                isr      <= '0;
                mask     <= '0;
                low      <= LAST;
            end else begin
                if (mask_wr) mask <= wr_data[NUM_IRQ-1:0];
                if (base_wr) base <= wr_data[VEC_W-1:0];
                irr_edge <= irr_edge_nxt;
                isr      <= isr_nxt;
                low      <= low_nxt;
                if (grant) begin
                    win_idx <= cand_found ? cand_idx : LAST;
                    spur    <= !cand_found;
                end
                if (state == S_GRANT) vec_reg <= base + VEC_W'(win_idx);
            end
        end
    end

endmodule
